// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM encoding,
// default byte width, byte-count width and grant-index width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DBIT_DEFAULT = 8;
  localparam int CNT_W        = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// from ptr+1, wrapping modulo N_REQ.
module uart_tx_arbiter_rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [GW-1:0]    grant,
  output logic             any_valid
);

  logic [GW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  // cand_idx[k] is the requester k+1 positions after the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = GW'((int'(ptr) + gi + 1) % N_REQ);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Walk from the farthest candidate down so the nearest hit wins.
  always_comb begin
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) grant = cand_idx[k];
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte streams: round-robin grant held for a
// whole packet (req_last or MAX_PKT bytes), one tx_start per byte.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int DBIT    = DBIT_DEFAULT,
  parameter  int MAX_PKT = 16,
  localparam int GW      = id_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  tx_start,
  output logic [DBIT-1:0]       tx_din,
  input  logic                  tx_done_tick,
  output logic [GW-1:0]         grant_id,
  output logic                  busy
);

  state_t           state_reg;
  logic [GW-1:0]    ptr_reg;
  logic [GW-1:0]    grant_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_reg;
  logic             tx_start_reg;
  logic [DBIT-1:0]  tx_din_reg;
  logic [GW-1:0]    pick;
  logic             any_valid;

  uart_tx_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (pick),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= GW'(N_REQ - 1);
      grant_reg    <= '0;
      cnt_reg      <= '0;
      last_reg     <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_din_reg   <= '0;
    end else begin
      tx_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_reg <= pick;
            cnt_reg   <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // An idle granted requester keeps the lock; it owns the gap.
          if (req_valid[grant_reg]) begin
            tx_din_reg   <= req_data[int'(grant_reg)*DBIT +: DBIT];
            last_reg     <= req_last[grant_reg];
            cnt_reg      <= cnt_reg + CNT_W'(1);
            tx_start_reg <= 1'b1;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          // A done tick in the start-pulse cycle cannot belong to this byte.
          if (tx_done_tick && !tx_start_reg) begin
            if (last_reg || (cnt_reg == CNT_W'(MAX_PKT))) begin
              ptr_reg   <= grant_reg;
              state_reg <= IDLE;
            end else begin
              state_reg <= SEND;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == SEND) && (grant_reg == GW'(gi));
    end
  endgenerate

  assign tx_start = tx_start_reg;
  assign tx_din   = tx_din_reg;
  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx (4 clocks per bit),
// a serial-line decoder and a scoreboard of expected grants and bytes.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int MAXP = 4;

  typedef struct packed {logic [1:0] id; logic [7:0] data; logic last;} src_t;
  typedef struct packed {logic [1:0] gid; logic [7:0] data;} exp_t;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_din;
  logic            tx_done_tick;
  logic [1:0]      grant_id;
  logic            busy;

  logic       u_busy, u_done, tx_line, spur;
  logic [9:0] u_shreg;
  logic [3:0] u_bit;
  logic [1:0] u_tick;

  src_t       src_q[$];
  exp_t       exp_q[$];
  logic [7:0] rx_exp[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;
  int n;

  uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .MAX_PKT(MAXP)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural uart_tx: start, 8 data bits LSB first, stop; done after stop.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_busy <= 1'b0; u_done <= 1'b0; tx_line <= 1'b1;
      u_shreg <= '0; u_bit <= '0; u_tick <= '0;
    end else begin
      u_done <= 1'b0;
      if (!u_busy) begin
        if (tx_start) begin
          u_busy <= 1'b1; u_shreg <= {1'b1, tx_din, 1'b0};
          u_bit <= '0; u_tick <= '0; tx_line <= 1'b0;
        end
      end else if (u_tick == 2'd3) begin
        u_tick <= '0;
        if (u_bit == 4'd9) begin
          u_busy <= 1'b0; u_done <= 1'b1;
        end else begin
          u_bit <= u_bit + 4'd1;
          tx_line <= u_shreg[u_bit + 4'd1];
        end
      end else begin
        u_tick <= u_tick + 2'd1;
      end
    end
  end

  assign tx_done_tick = u_done | spur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_src(input logic [1:0] id, input logic [7:0] d, input logic l);
    src_t s;
    s.id = id; s.data = d; s.last = l;
    src_q.push_back(s);
  endtask

  task automatic expect_tx(input logic [1:0] g, input logic [7:0] d);
    exp_t e;
    e.gid = g; e.data = d;
    exp_q.push_back(e);
    rx_exp.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || src_q.size() != 0 || exp_q.size() != 0 || rx_exp.size() != 0) && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_timeout"}, 32'(k >= 3000), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Requester models: each presents its oldest queued byte, popped on handshake.
  initial begin : driver
    int hs_idx;
    bit found;
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      hs_idx = -1;
      for (int i = 0; i < N; i++) begin
        found = 1'b0;
        req_valid[i] = 1'b0;
        for (int j = 0; j < src_q.size(); j++) begin
          if (!found && int'(src_q[j].id) == i) begin
            found = 1'b1;
            req_valid[i] = 1'b1;
            req_data[i*DB +: DB] = src_q[j].data;
            req_last[i] = src_q[j].last;
            if (req_ready[i]) hs_idx = j;
          end
        end
      end
      @(posedge clk);
      if (!reset && hs_idx >= 0) src_q.delete(hs_idx);
    end
  end

  // Scoreboard monitor: every tx_start must match the next expected grant/byte.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("ready_onehot_in_send", 32'(($countones(req_ready) > 1) || (req_ready != '0 && !busy)), 32'd0);
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            check("unexpected_tx_start", 32'(tx_din), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("grant_id", 32'(grant_id), 32'(e.gid));
            check("tx_din", 32'(tx_din), 32'(e.data));
            $display("tx grant=%0d din=%02h expected grant=%0d din=%02h", grant_id, tx_din, e.gid, e.data);
          end
        end
      end
    end
  end

  // Serial decoder: samples each bit mid-cell; a reset aborts the frame.
  initial begin : rx_mon
    logic [9:0] fr;
    logic [7:0] eb;
    bit ab;
    forever begin
      @(negedge clk);
      if (!reset && tx_line === 1'b0) begin
        ab = 1'b0; fr = '0;
        for (int k = 1; k <= 38; k++) begin
          @(negedge clk);
          if (reset) begin ab = 1'b1; break; end
          if (k % 4 == 2) fr[k/4] = tx_line;
        end
        if (!ab) begin
          if (rx_exp.size() == 0) begin
            check("unexpected_serial_frame", 32'(fr), 32'hFFFF_FFFF);
          end else begin
            eb = rx_exp.pop_front();
            check("serial_frame", 32'(fr), 32'({1'b1, eb, 1'b0}));
            $display("rx byte=%02h expected=%02h", fr[8:1], eb);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; spur = 1'b0;
    repeat (2) @(negedge clk); #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_line", 32'(tx_line), 32'd1);
    @(negedge clk); reset = 1'b0;

    // 1: single byte, latency valid->tx_start = 2 cycles
    @(posedge clk); #1;
    push_src(2'd0, 8'hA5, 1'b1); expect_tx(2'd0, 8'hA5);
    n = 0;
    while (!req_valid[0] && n < 10) begin @(negedge clk); #1; n++; end
    t0 = cyc;
    n = 0;
    while (!tx_start && n < 10) begin @(negedge clk); #1; n++; end
    check("t1_latency", 32'(cyc - t0), 32'd2);
    wait_idle("t1");
    check("t1_busy_after_done", 32'(busy), 32'd0);

    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;

    // 2: all four valid, then requesters 1 and 3 with pointer at 3
    for (int i = 0; i < 4; i++) push_src(2'(i), 8'(8'h10 + i), 1'b1);
    expect_tx(2'd0, 8'h10); expect_tx(2'd1, 8'h11);
    expect_tx(2'd2, 8'h12); expect_tx(2'd3, 8'h13);
    wait_idle("t2a");
    push_src(2'd3, 8'h23, 1'b1); push_src(2'd1, 8'h21, 1'b1);
    expect_tx(2'd1, 8'h21); expect_tx(2'd3, 8'h23);
    wait_idle("t2b");

    // 3: three-byte packet from 2 holds off requester 0
    push_src(2'd2, 8'h01, 1'b0); push_src(2'd2, 8'h02, 1'b0); push_src(2'd2, 8'h03, 1'b1);
    expect_tx(2'd2, 8'h01); expect_tx(2'd2, 8'h02); expect_tx(2'd2, 8'h03);
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); #1; n++; end
    push_src(2'd0, 8'hC0, 1'b1); expect_tx(2'd0, 8'hC0);
    wait_idle("t3");

    // 4: forced release after MAX_PKT bytes; last only closes the resumed part
    for (int i = 1; i <= 6; i++) push_src(2'd1, 8'(8'h40 + i), 1'(i == 6));
    push_src(2'd2, 8'h2A, 1'b1);
    for (int i = 1; i <= 4; i++) expect_tx(2'd1, 8'(8'h40 + i));
    expect_tx(2'd2, 8'h2A); expect_tx(2'd1, 8'h45); expect_tx(2'd1, 8'h46);
    wait_idle("t4");

    // 5: spurious done ticks in IDLE and in SEND
    spur = 1'b1; @(negedge clk); spur = 1'b0;
    repeat (4) @(negedge clk); #1;
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_grant", 32'(grant_id), 32'd1);
    push_src(2'd3, 8'h31, 1'b0); expect_tx(2'd3, 8'h31);
    n = 0;
    while (!(req_ready == 4'b1000 && exp_q.size() == 0 && rx_exp.size() == 0) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    spur = 1'b1; @(negedge clk); spur = 1'b0;
    repeat (4) @(negedge clk); #1;
    check("t5_send_ready", 32'(req_ready), 32'h8);
    check("t5_send_busy", 32'(busy), 32'd1);
    check("t5_send_grant", 32'(grant_id), 32'd3);
    push_src(2'd3, 8'h32, 1'b1); expect_tx(2'd3, 8'h32);
    wait_idle("t5");

    // 6: reset while a frame is on the line, then priority restarts at 0
    push_src(2'd1, 8'h61, 1'b1); push_src(2'd2, 8'h5A, 1'b1);
    expect_tx(2'd1, 8'h61); expect_tx(2'd2, 8'h5A);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); #1; n++; end
    repeat (10) @(negedge clk);
    check("t6_in_wait_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_tx_start", 32'(tx_start), 32'd0);
    check("t6_rst_tx_din", 32'(tx_din), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    check("t6_rst_grant_id", 32'(grant_id), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_tx_line", 32'(tx_line), 32'd1);
    rx_exp.delete();
    repeat (2) @(negedge clk); reset = 1'b0;
    push_src(2'd2, 8'h72, 1'b1); push_src(2'd0, 8'h70, 1'b1);
    expect_tx(2'd0, 8'h70); expect_tx(2'd2, 8'h72);
    wait_idle("t6");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
